restoring_div_nbit: RTL and testbench

RESTORING_DIV_NBIT -- requirements
Module: restoring_div_nbit

---
 rtl/restoring_div_pkg.sv | 14 +
 rtl/ripple_sub_nbit.sv | 31 +++
 rtl/restoring_div_nbit.sv | 151 +++++++++++++++
 tb/tb_restoring_div_nbit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/restoring_div_pkg.sv
// restoring_div_pkg
// Shared definitions for the restoring divider: the controller state encoding
// and the default operand width.
package restoring_div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_sub_nbit.sv
// ripple_sub_nbit
// Ripple-borrow subtractor: o_diff = i_x - i_y (mod 2^WIDTH). o_borrow is set
// when i_y > i_x.
// Ports:
//   i_x      [WIDTH-1:0]  minuend
//   i_y      [WIDTH-1:0]  subtrahend
//   o_diff   [WIDTH-1:0]  difference
//   o_borrow              borrow out of the MSB stage
module ripple_sub_nbit #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    // The borrow chain lives in a procedural variable so each stage feeds the
    // next combinationally, one full-subtractor cell per bit.
    always_comb begin
        logic w_bin;
        w_bin  = 1'b0;
        o_diff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_diff[i] = i_x[i] ^ i_y[i] ^ w_bin;
            w_bin     = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_bin);
        end
        o_borrow = w_bin;
    end

endmodule

// File: rtl/restoring_div_nbit.sv
// restoring_div_nbit
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A start seen in IDLE latches a and b; WIDTH RUN cycles later done pulses
// for one cycle with quot/rem valid. quot/rem hold until the next DONE.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              request, honoured only in IDLE
//   a, b [WIDTH-1:0]   dividend, divisor (sampled on the accepting edge)
//   busy               high while iterating
//   done               one-cycle completion pulse
//   quot, rem          results
//   div_by_zero        divisor was zero (only with the fast path)
// Build option:
//   DIV_BY_ZERO_FAST_EN  b=0 skips iteration: IDLE->DONE with quot all-ones,
//                        rem=a, div_by_zero=1. Undefined: b=0 runs the normal
//                        iterations (same quot/rem) and div_by_zero is tied 0.
module restoring_div_nbit
    import restoring_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem_w;
    logic [WIDTH-1:0] r_qw;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_unused_msb;

    assign w_trial = {r_rem_w, r_dvd[WIDTH-1]};

    ripple_sub_nbit #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .i_x      (w_trial),
        .i_y      ({1'b0, r_b}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // Without a borrow the difference is below b, so its MSB is always zero
    // and the remainder fits in WIDTH bits.
    assign w_rem_nxt    = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_q_nxt      = {r_qw[WIDTH-2:0], ~w_borrow};
    assign w_unused_msb = w_diff[WIDTH];

`ifdef DIV_BY_ZERO_FAST_EN
    logic r_dbz;
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_b     <= '0;
            r_dvd   <= '0;
            r_rem_w <= '0;
            r_qw    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
`ifdef DIV_BY_ZERO_FAST_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b     <= b;
                        r_dvd   <= a;
                        r_rem_w <= '0;
                        r_qw    <= '0;
                        r_cnt   <= '0;
`ifdef DIV_BY_ZERO_FAST_EN
                        if (b == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_quot  <= '1;
                            r_rem   <= a;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_dbz   <= 1'b0;
                        end
`else
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    r_rem_w <= w_rem_nxt;
                    r_qw    <= w_q_nxt;
                    r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= w_q_nxt;
                        r_rem   <= w_rem_nxt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quot = r_quot;
    assign rem  = r_rem;

endmodule

// File: tb/tb_restoring_div_nbit.sv
// tb_restoring_div_nbit
// Directed bench for restoring_div_nbit at WIDTH=4. Honours
// DIV_BY_ZERO_FAST_EN to pick the expected divide-by-zero behaviour.
module tb_restoring_div_nbit;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef DIV_BY_ZERO_FAST_EN
    localparam int   DBZ_LAT = 0;
    localparam logic DBZ_FLG = 1'b1;
`else
    localparam int   DBZ_LAT = W;
    localparam logic DBZ_FLG = 1'b0;
`endif

    restoring_div_nbit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete division: accept, scramble inputs while running, wait for
    // done (bounded), check latency/busy/results, then check the pulse ends
    // and the results hold.
    task automatic run_div(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input int exp_lat, input logic [W-1:0] exp_q,
                           input logic [W-1:0] exp_r, input logic exp_dbz);
        int lat;
        int nbusy;
        a     = ta;
        b     = tb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        nbusy = 0;
        for (lat = 0; lat < 20 && done !== 1'b1; lat++) begin
            if (busy === 1'b1) nbusy++;
            tick();
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, nbusy, exp_lat);
        chk({tag, " busy_at_done"}, busy, 1'b0);
        chk({tag, " quot"}, quot, exp_q);
        chk({tag, " rem"}, rem, exp_r);
        chk({tag, " dbz"}, div_by_zero, exp_dbz);
        tick();
        chk({tag, " done_one_cycle"}, done, 1'b0);
        chk({tag, " quot_hold"}, quot, exp_q);
        chk({tag, " rem_hold"}, rem, exp_r);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] q_seen;
        logic [W-1:0] r_seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset quot", quot, 4'd0);
        chk("reset rem", rem, 4'd0);
        chk("reset dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        tick();

        // 13/3 = 4 r1, four busy cycles
        run_div("d13_3", 4'd13, 4'd3, W, 4'd4, 4'd1, 1'b0);
        run_div("d15_1", 4'd15, 4'd1, W, 4'd15, 4'd0, 1'b0);

        // idle with wiggling inputs: results must hold
        a = 4'd2; b = 4'd9;
        tick();
        a = 4'd11; b = 4'd0;
        tick();
        tick();
        chk("idle hold quot", quot, 4'd15);
        chk("idle hold rem", rem, 4'd0);
        chk("idle busy", busy, 1'b0);

        run_div("d5_7", 4'd5, 4'd7, W, 4'd0, 4'd5, 1'b0);
        run_div("d9_0", 4'd9, 4'd0, DBZ_LAT, 4'd15, 4'd9, DBZ_FLG);

        // start re-pulsed mid-run with other operands: ignored
        a = 4'd12; b = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 4'd1; b = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone  = 0;
        q_seen = '0;
        r_seen = '0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) begin
                ndone++;
                q_seen = quot;
                r_seen = rem;
            end
            tick();
        end
        chk("restart done_count", ndone, 1);
        chk("restart quot", q_seen, 4'd2);
        chk("restart rem", r_seen, 4'd2);

        // reset two cycles into RUN aborts the operation
        a = 4'd13; b = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort quot", quot, 4'd0);
        chk("abort rem", rem, 4'd0);
        chk("abort dbz", div_by_zero, 1'b0);
        tick();
        rst = 1'b0;
        chk("abort no_done", done, 1'b0);
        run_div("d7_2", 4'd7, 4'd2, W, 4'd3, 4'd1, 1'b0);

        // every dividend against every non-zero divisor
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 1; ib < 16; ib++) begin
                run_div($sformatf("sweep %0d/%0d", ia, ib), W'(ia), W'(ib), W,
                        W'(ia / ib), W'(ia % ib), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
